gpu_blitter: RTL

//  Parametrised CHIP-8 display engine: executes CLEAR and DRAW (XOR sprite blit with collision) on a
//  1bpp row-major framebuffer held in shared byte memory. Sits between CPU command issue and the memory

---
 rtl/gpu_blitter_if.sv | 55 +++++
 rtl/gpu_blitter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_blitter_if.sv
`default_nettype none
// ============================================================================
// Module      : gpu_blitter_if
// Description : Command and shared-memory bus between the CPU command issue,
//               the gpu_blitter display engine and the memory arbiter.
//               Also supplies default command codes when gpu_cmd.v is absent.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef GPU_CMD_CLEAR
`define GPU_CMD_CLEAR 4'h1
`endif
`ifndef GPU_CMD_DRAW
`define GPU_CMD_DRAW 4'h2
`endif

interface gpu_blitter_if #(
  parameter int ADDR_W = 12
);
  // command side
  logic [3:0]        gpu_cmd;
  logic [15:0]       gpu_draw_offset;
  logic [7:0]        gpu_draw_length;
  logic [7:0]        gpu_draw_x;
  logic [7:0]        gpu_draw_y;
  logic              gpu_cmd_submitted;
  logic              gpu_ready;
  logic              gpu_collision;
  // memory side
  logic              gpu_mem_read;
  logic [ADDR_W-1:0] gpu_mem_read_addr;
  logic [7:0]        gpu_mem_read_data;
  logic              gpu_mem_read_ack;
  logic              gpu_mem_write;
  logic [ADDR_W-1:0] gpu_mem_write_addr;
  logic [7:0]        gpu_mem_write_data;

  // the display engine
  modport slave (
    input  gpu_cmd, gpu_draw_offset, gpu_draw_length, gpu_draw_x, gpu_draw_y,
           gpu_cmd_submitted, gpu_mem_read_data, gpu_mem_read_ack,
    output gpu_ready, gpu_collision, gpu_mem_read, gpu_mem_read_addr,
           gpu_mem_write, gpu_mem_write_addr, gpu_mem_write_data
  );

  // the CPU / memory arbiter side
  modport master (
    output gpu_cmd, gpu_draw_offset, gpu_draw_length, gpu_draw_x, gpu_draw_y,
           gpu_cmd_submitted, gpu_mem_read_data, gpu_mem_read_ack,
    input  gpu_ready, gpu_collision, gpu_mem_read, gpu_mem_read_addr,
           gpu_mem_write, gpu_mem_write_addr, gpu_mem_write_data
  );
endinterface

`default_nettype wire

// File: rtl/gpu_blitter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_blitter
// Description : CHIP-8 style display engine. Executes CLEAR and DRAW (XOR
//               sprite blit with collision detect) on a 1bpp row-major
//               framebuffer in shared byte memory, MSB = leftmost pixel.
//               Optional macro GPU_CLIP_EN: clip sprites at the right and
//               bottom framebuffer edges instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================

module gpu_blitter #(
  parameter int ADDR_W    = 12,
  parameter int FB_BASE   = 'h100,
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 32,
  parameter int MAX_ROWS  = 15
) (
  input  wire            clk,
  input  wire            rst,
  gpu_blitter_if.slave   bus
);

  localparam int BPR     = FB_WIDTH / 8;
  localparam int N_BYTES = FB_WIDTH * FB_HEIGHT / 8;
  localparam int XW      = $clog2(FB_WIDTH);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] X_MASK   = ADDR_W'(FB_WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_MASK   = ADDR_W'(FB_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'(BPR - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(BPR - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BYTES - 1);
  localparam logic [ADDR_W-1:0] HEIGHT   = ADDR_W'(FB_HEIGHT);
  localparam logic [7:0]        ROW_CLAMP = 8'(MAX_ROWS);

`ifdef GPU_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DECODE   = 4'd1,
    S_CLEAR    = 4'd2,
    S_RD_SPR   = 4'd3,
    S_RD_FB0   = 4'd4,
    S_WR_FB0   = 4'd5,
    S_RD_FB1   = 4'd6,
    S_WR_FB1   = 4'd7,
    S_NEXT_ROW = 4'd8
  } state_t;

  state_t state;
  state_t state_nxt;

  // latched command
  logic [3:0]        cmd_lat;
  logic [ADDR_W-1:0] off_lat;
  logic [7:0]        len_lat;
  logic [7:0]        x_lat;
  logic [7:0]        y_lat;

  // draw / clear progress
  logic [ADDR_W-1:0] x0;
  logic [ADDR_W-1:0] y0;
  logic [7:0]        rows;
  logic [7:0]        row_cnt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        spr_byte;
  logic [7:0]        fb_byte;
  logic              collision;

  // upper sprite-offset bits are outside the address space
  generate
    if (ADDR_W < 16) begin : g_offset_tail
      wire unused_offset_hi = &{1'b0, bus.gpu_draw_offset[15:ADDR_W]};
    end
  endgenerate

  // row / column address arithmetic for the current sprite row
  logic [ADDR_W-1:0] y_sum;
  logic [ADDR_W-1:0] fb_row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] spr_addr;
  logic [2:0]        shift;
  logic [15:0]       mask_pair;
  logic [7:0]        mask_cur;
  logic [7:0]        fb_new;
  logic              hit;
  logic              need_byte1;
  logic              last_row;
  logic [7:0]        rows_eff;
  logic [ADDR_W-1:0] x0_dec;
  logic [ADDR_W-1:0] y0_dec;

  assign y_sum      = y0 + ADDR_W'(row_cnt);
  assign fb_row     = y_sum & Y_MASK;
  assign col        = x0 >> 3;
  assign row_base   = BASE + (fb_row << (XW - 3));
  assign addr0      = row_base + col;
  assign addr1      = row_base + ((col + ADDR_W'(1)) & COL_MASK);
  assign spr_addr   = off_lat + ADDR_W'(row_cnt);
  assign shift      = x0[2:0];
  // the sprite byte straddles two framebuffer bytes: {left part, right part}
  assign mask_pair  = {spr_byte, 8'h00} >> shift;
  assign mask_cur   = (state == S_WR_FB1) ? mask_pair[7:0] : mask_pair[15:8];
  assign fb_new     = fb_byte ^ mask_cur;
  assign hit        = |(fb_byte & mask_cur);
  assign need_byte1 = (shift != 3'd0) && !(CLIP && (col == LAST_COL));
  assign last_row   = ((row_cnt + 8'd1) == rows) ||
                      (CLIP && ((y_sum + ADDR_W'(1)) >= HEIGHT));
  assign rows_eff   = (len_lat > ROW_CLAMP) ? ROW_CLAMP : len_lat;
  assign x0_dec     = ADDR_W'(x_lat) & X_MASK;
  assign y0_dec     = ADDR_W'(y_lat) & Y_MASK;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode and bus outputs
  always_comb begin
    state_nxt              = state;
    bus.gpu_ready          = 1'b0;
    bus.gpu_collision      = collision;
    bus.gpu_mem_read       = 1'b0;
    bus.gpu_mem_read_addr  = '0;
    bus.gpu_mem_write      = 1'b0;
    bus.gpu_mem_write_addr = '0;
    bus.gpu_mem_write_data = 8'h00;
    case (state)
      S_IDLE: begin
        bus.gpu_ready = 1'b1;
        if (bus.gpu_cmd_submitted) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (cmd_lat == `GPU_CMD_CLEAR)                        state_nxt = S_CLEAR;
        else if ((cmd_lat == `GPU_CMD_DRAW) && (rows_eff != 8'd0)) state_nxt = S_RD_SPR;
        else                                                  state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        bus.gpu_mem_write      = 1'b1;
        bus.gpu_mem_write_addr = BASE + idx;
        if (idx == LAST_IDX) state_nxt = S_IDLE;
      end
      S_RD_SPR: begin
        bus.gpu_mem_read      = 1'b1;
        bus.gpu_mem_read_addr = spr_addr;
        if (bus.gpu_mem_read_ack) state_nxt = S_RD_FB0;
      end
      S_RD_FB0: begin
        bus.gpu_mem_read      = 1'b1;
        bus.gpu_mem_read_addr = addr0;
        if (bus.gpu_mem_read_ack) state_nxt = S_WR_FB0;
      end
      S_WR_FB0: begin
        bus.gpu_mem_write      = 1'b1;
        bus.gpu_mem_write_addr = addr0;
        bus.gpu_mem_write_data = fb_new;
        state_nxt = need_byte1 ? S_RD_FB1 : S_NEXT_ROW;
      end
      S_RD_FB1: begin
        bus.gpu_mem_read      = 1'b1;
        bus.gpu_mem_read_addr = addr1;
        if (bus.gpu_mem_read_ack) state_nxt = S_WR_FB1;
      end
      S_WR_FB1: begin
        bus.gpu_mem_write      = 1'b1;
        bus.gpu_mem_write_addr = addr1;
        bus.gpu_mem_write_data = fb_new;
        state_nxt = S_NEXT_ROW;
      end
      S_NEXT_ROW: begin
        state_nxt = last_row ? S_IDLE : S_RD_SPR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // command latch, progress counters, read capture and collision flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_lat   <= 4'h0;
      off_lat   <= '0;
      len_lat   <= 8'h00;
      x_lat     <= 8'h00;
      y_lat     <= 8'h00;
      x0        <= '0;
      y0        <= '0;
      rows      <= 8'h00;
      row_cnt   <= 8'h00;
      idx       <= '0;
      spr_byte  <= 8'h00;
      fb_byte   <= 8'h00;
      collision <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.gpu_cmd_submitted) begin
            cmd_lat <= bus.gpu_cmd;
            off_lat <= bus.gpu_draw_offset[ADDR_W-1:0];
            len_lat <= bus.gpu_draw_length;
            x_lat   <= bus.gpu_draw_x;
            y_lat   <= bus.gpu_draw_y;
          end
        end
        S_DECODE: begin
          idx <= '0;
          if (cmd_lat == `GPU_CMD_DRAW) begin
            collision <= 1'b0;
            x0        <= x0_dec;
            y0        <= y0_dec;
            rows      <= rows_eff;
            row_cnt   <= 8'h00;
          end
        end
        S_CLEAR:    idx <= idx + ADDR_W'(1);
        S_RD_SPR:   if (bus.gpu_mem_read_ack) spr_byte <= bus.gpu_mem_read_data;
        S_RD_FB0,
        S_RD_FB1:   if (bus.gpu_mem_read_ack) fb_byte <= bus.gpu_mem_read_data;
        S_WR_FB0,
        S_WR_FB1:   collision <= collision | hit;
        S_NEXT_ROW: row_cnt <= row_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
